// File: rtl/cap_pkg.sv
// Shared definitions for the trace capture path: depth, address width and FSM states.
// The RAM dump side imports the same AW so both ends agree on address width.
package cap_pkg;

    localparam int ENTRIES = 512;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } cap_state_t;

    function automatic logic owns_ram(input cap_state_t s);
        return (s == FILL) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Command/trigger inputs and RAM write-side outputs of the capture controller.
// The master drives requests, the slave is the controller itself.
interface capture_ctrl_if;
    import cap_pkg::*;

    logic          cap_start;
    logic          trig_in;
    logic [AW-1:0] trig_pos;
    logic [3:0]    decimator;
    logic          dump_busy;
    logic          we;
    logic          cap_en;
    logic [AW-1:0] cap_addr;
    logic [AW-1:0] trace_end;
    logic          armed;
    logic          capture_done;

    modport master (
        output cap_start, trig_in, trig_pos, decimator, dump_busy,
        input  we, cap_en, cap_addr, trace_end, armed, capture_done
    );

    modport slave (
        input  cap_start, trig_in, trig_pos, decimator, dump_busy,
        output we, cap_en, cap_addr, trace_end, armed, capture_done
    );

endinterface

// File: rtl/cap_decimator.sv
// Divide-by-2^decimator sample strobe. tick is a look-ahead: it is high when the
// counter value about to be loaded matches the limit, so the owner can register it.
module cap_decimator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [3:0] decimator,
    output logic       tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] limit;

    assign limit = (16'd1 << decimator) - 16'd1;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clr || (cnt_q >= limit)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_d == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Trace RAM write controller: decimated write strobes, wrapping pointer, pre-trigger
// fill gating and post-trigger countdown ending in a latched trace_end.
module capture_ctrl
    import cap_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] trace_end_q, trace_end_d;
    logic [AW-1:0] tp_q, tp_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [3:0]    dec_q, dec_d;
    logic          we_q, we_d;
    logic          cap_en_q, cap_en_d;
    logic          armed_q, armed_d;
    logic          done_q, done_d;

    logic          start;
    logic          tick;
    logic [3:0]    dec_eff;
    logic [CW-1:0] pre_target;
    logic          fill_hit;
    logic          post_hit;
    logic [AW-1:0] last_addr;

    assign start      = bus.cap_start && !bus.dump_busy && ((state_q == IDLE) || (state_q == DONE));
    assign dec_eff    = start ? bus.decimator : dec_q;
    assign pre_target = CW'(ENTRIES) - {1'b0, tp_q};
    assign fill_hit   = cap_en_q && ((fill_cnt_q + CW'(1)) == pre_target);
    assign post_hit   = cap_en_q && ((post_cnt_q + AW'(1)) == tp_q);
    // A write coinciding with the trigger is the newest pre-trigger sample.
    assign last_addr  = cap_en_q ? ptr_q : (ptr_q - AW'(1));

    cap_decimator u_decimator (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .decimator (dec_eff),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            trace_end_q <= '0;
            tp_q        <= '0;
            post_cnt_q  <= '0;
            fill_cnt_q  <= '0;
            dec_q       <= '0;
            we_q        <= 1'b0;
            cap_en_q    <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            trace_end_q <= trace_end_d;
            tp_q        <= tp_d;
            post_cnt_q  <= post_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            dec_q       <= dec_d;
            we_q        <= we_d;
            cap_en_q    <= cap_en_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = FILL;
            FILL:       if (fill_hit) state_d = ARMED;
            ARMED:      if (bus.trig_in) state_d = (tp_q == '0) ? DONE : POST;
            POST:       if (post_hit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        trace_end_d = trace_end_q;
        tp_d        = tp_q;
        dec_d       = dec_q;
        post_cnt_d  = post_cnt_q;
        fill_cnt_d  = fill_cnt_q;

        if (start) begin
            tp_d       = bus.trig_pos;
            dec_d      = bus.decimator;
            ptr_d      = '0;
            fill_cnt_d = '0;
        end else if (cap_en_q) begin
            ptr_d = ptr_q + AW'(1);
        end

        if ((state_q == FILL) && cap_en_q) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end

        if ((state_q == ARMED) && bus.trig_in) begin
            post_cnt_d = '0;
            if (tp_q == '0) begin
                trace_end_d = last_addr;
            end
        end else if ((state_q == POST) && cap_en_q) begin
            post_cnt_d = post_cnt_q + AW'(1);
            if (post_hit) begin
                trace_end_d = ptr_q;
            end
        end

        we_d     = owns_ram(state_d);
        cap_en_d = tick && owns_ram(state_d);
        armed_d  = (state_d == ARMED);
        done_d   = (state_d == DONE);
    end

    assign bus.we           = we_q;
    assign bus.cap_en       = cap_en_q;
    assign bus.cap_addr     = ptr_q;
    assign bus.trace_end    = trace_end_q;
    assign bus.armed        = armed_q;
    assign bus.capture_done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: table of full captures plus hand-written
// sequences for ignored starts, async reset mid-capture and restart.
module tb_capture_ctrl;
    import cap_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    capture_ctrl_if bus();

    capture_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int dec;
        int tp;
        int n_trig;      // ARMED writes seen before the trigger
        bit gap;         // 1: trigger in the first no-write cycle after n_trig writes
        bit fill_trig;   // pulse trig_in at FILL writes 10 and 300
        int exp_armed_at;
        int exp_total;
        int exp_end;
    } vec_t;

    vec_t vecs[6];

    task automatic run_capture(input int idx, input vec_t v);
        int cyc, writes, armed_writes, armed_at, prev_en, last_en, trig_cyc;
        int bad_addr, bad_gap, bad_we, bad_drop, quiet_bad, exp_addr;
        bit armed_seen, trig_done, done_seen;
        cyc = 0; writes = 0; armed_writes = 0; armed_at = -1; prev_en = -1;
        last_en = -1; trig_cyc = -1; bad_addr = 0; bad_gap = 0; bad_we = 0;
        bad_drop = 0; quiet_bad = 0; exp_addr = 0;
        armed_seen = 0; trig_done = 0; done_seen = 0;

        @(negedge clk);
        bus.decimator = v.dec[3:0];
        bus.trig_pos  = v.tp[AW-1:0];
        bus.cap_start = 1'b1;
        @(negedge clk);
        bus.cap_start = 1'b0;
        check($sformatf("v%0d we_rise", idx), bus.we, 1);

        while (!done_seen && cyc < 20000) begin
            if (trig_done && (cyc == trig_cyc + 1) && bus.armed) bad_drop++;
            if (bus.capture_done) begin
                done_seen = 1;
            end else begin
                if (!bus.we) bad_we++;
                if (bus.armed && !armed_seen) begin
                    armed_seen = 1;
                    armed_at   = writes;
                end
                if (bus.cap_en) begin
                    if (bus.cap_addr != exp_addr) bad_addr++;
                    if (cyc - prev_en != (1 << v.dec)) bad_gap++;
                    prev_en  = cyc;
                    last_en  = cyc;
                    exp_addr = (exp_addr + 1) % ENTRIES;
                    writes++;
                    if (armed_seen) armed_writes++;
                end
                bus.trig_in = 1'b0;
                if (v.fill_trig && !armed_seen && bus.cap_en && (writes == 10 || writes == 300))
                    bus.trig_in = 1'b1;
                if (armed_seen && !trig_done && (armed_writes >= v.n_trig) &&
                    (v.gap ? !bus.cap_en : bus.cap_en)) begin
                    bus.trig_in = 1'b1;
                    trig_done   = 1;
                    trig_cyc    = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.trig_in = 1'b0;

        check($sformatf("v%0d done_reached", idx), done_seen, 1);
        check($sformatf("v%0d armed_after_writes", idx), armed_at, v.exp_armed_at);
        check($sformatf("v%0d addr_seq_errs", idx), bad_addr, 0);
        check($sformatf("v%0d strobe_gap_errs", idx), bad_gap, 0);
        check($sformatf("v%0d we_hold_errs", idx), bad_we, 0);
        check($sformatf("v%0d armed_drop_errs", idx), bad_drop, 0);
        check($sformatf("v%0d total_writes", idx), writes, v.exp_total);
        check($sformatf("v%0d trace_end", idx), bus.trace_end, v.exp_end);
        check($sformatf("v%0d we_at_done", idx), bus.we, 0);
        check($sformatf("v%0d cap_en_at_done", idx), bus.cap_en, 0);
        check($sformatf("v%0d armed_at_done", idx), bus.armed, 0);
        if (v.tp == 0) check($sformatf("v%0d done_latency", idx), cyc - trig_cyc, 1);
        else           check($sformatf("v%0d done_latency", idx), cyc - last_en, 1);

        repeat (6) begin
            @(negedge clk);
            if (bus.cap_en || !bus.capture_done) quiet_bad++;
        end
        check($sformatf("v%0d quiet_after_done", idx), quiet_bad, 0);
        check($sformatf("v%0d trace_end_held", idx), bus.trace_end, v.exp_end);
    endtask

    initial begin
        int waited;
        bus.cap_start = 1'b0;
        bus.trig_in   = 1'b0;
        bus.trig_pos  = '0;
        bus.decimator = '0;
        bus.dump_busy = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        check("rst we", bus.we, 0);
        check("rst cap_en", bus.cap_en, 0);
        check("rst cap_addr", bus.cap_addr, 0);
        check("rst trace_end", bus.trace_end, 0);
        check("rst armed", bus.armed, 0);
        check("rst capture_done", bus.capture_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //          dec tp   ntrig gap ftrig armed_at total end
        vecs[0] = '{0,  100, 150,  0,  1,    412,     662,  149};
        vecs[1] = '{2,  10,  5,    0,  0,    502,     517,  4};
        vecs[2] = '{1,  0,   8,    1,  0,    512,     520,  7};
        vecs[3] = '{0,  511, 1,    0,  0,    1,       513,  0};
        vecs[4] = '{0,  1,   3,    0,  0,    511,     515,  2};
        vecs[5] = '{3,  1,   2,    1,  0,    511,     514,  1};

        for (int i = 0; i < 6; i++) begin
            run_capture(i, vecs[i]);
            $display("capture %0d: dec=%0d trig_pos=%0d trace_end=%0d", i, vecs[i].dec, vecs[i].tp, bus.trace_end);
        end

        // Start while the dump owns the RAMs is ignored.
        @(negedge clk);
        bus.dump_busy = 1'b1;
        bus.cap_start = 1'b1;
        @(negedge clk);
        bus.cap_start = 1'b0;
        check("busy_start we", bus.we, 0);
        check("busy_start capture_done", bus.capture_done, 1);
        repeat (3) @(negedge clk);
        check("busy_start trace_end", bus.trace_end, vecs[5].exp_end);
        bus.dump_busy = 1'b0;
        $display("dump_busy start: we=%0d done=%0d", bus.we, bus.capture_done);

        // Start during ARMED is ignored.
        bus.decimator = 4'd0;
        bus.trig_pos  = 9'd100;
        bus.cap_start = 1'b1;
        @(negedge clk);
        bus.cap_start = 1'b0;
        waited = 0;
        while (!bus.armed && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("armed_reached", bus.armed, 1);
        check("armed first addr", bus.cap_addr, 412);
        bus.cap_start = 1'b1;
        @(negedge clk);
        bus.cap_start = 1'b0;
        check("armed_start armed", bus.armed, 1);
        check("armed_start cap_addr", bus.cap_addr, 413);
        check("armed_start we", bus.we, 1);
        $display("armed start: armed=%0d cap_addr=%0d", bus.armed, bus.cap_addr);

        // Trigger, run into POST, then reset asynchronously between clock edges.
        bus.trig_in = 1'b1;
        @(negedge clk);
        bus.trig_in = 1'b0;
        check("post armed", bus.armed, 0);
        check("post cap_addr", bus.cap_addr, 414);
        repeat (20) @(negedge clk);
        check("post we", bus.we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async we", bus.we, 0);
        check("async cap_en", bus.cap_en, 0);
        check("async cap_addr", bus.cap_addr, 0);
        check("async trace_end", bus.trace_end, 0);
        check("async armed", bus.armed, 0);
        check("async capture_done", bus.capture_done, 0);
        $display("async reset: we=%0d cap_en=%0d cap_addr=%0d", bus.we, bus.cap_en, bus.cap_addr);
        @(negedge clk);
        rst_n = 1'b1;

        bus.cap_start = 1'b1;
        @(negedge clk);
        bus.cap_start = 1'b0;
        check("restart we", bus.we, 1);
        check("restart cap_en", bus.cap_en, 1);
        check("restart cap_addr", bus.cap_addr, 0);
        @(negedge clk);
        check("restart cap_addr2", bus.cap_addr, 1);
        $display("restart: we=%0d cap_addr=%0d", bus.we, bus.cap_addr);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
